ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative M-extension multiply/divide unit in the EX stage of the 5-stage pipeline.
- Consumes the forwarded ALU operands (post-forwarding rs1/rs2 values) and produces a 32-bit result for EX/MEM.
- Holds the pipeline through a busy signal while an operation is in flight.
- Radix-2 shift-add multiply and restoring divide; one result bit per cycle.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is verified.
- CNT_W, 5, iteration counter width. Must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  request a new operation; sampled only when busy_o=0.
- kill_i  input  1  pipeline flush; aborts any in-flight operation.
- op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a_i  input  WIDTH  forwarded rs1 operand.
- b_i  input  WIDTH  forwarded rs2 operand.
- result_o  output  WIDTH  result; valid while valid_o=1, then held.
- valid_o  output  1  one-cycle result strobe.
- busy_o  output  1  operation in flight; hazard logic stalls IF/ID/EX while high.

Behaviour:
- Reset: state IDLE, result_o=0, valid_o=0, busy_o=0, counter=0, internal registers 0.
- Reset mid-operation: the operation is discarded and no valid_o is produced.
- States:
  - IDLE: accepts start.
  - CALC: iterating.
  - FIN: sign fix-up and result latch.
- busy_o=1 exactly when state is CALC or FIN (registered).
- IDLE, start_i=1, kill_i=0, sampled at edge N:
  - Latch op, operands and operand signs.
  - Signed ops take absolute values (|-2^31| stays 0x80000000 as unsigned).
  - Go to CALC with counter=WIDTH-1.
- CALC: one iteration per edge.
  - Multiply: conditionally add multiplicand to the 2*WIDTH accumulator, then shift.
  - Divide: shift remainder/quotient left, trial subtract, restore on negative.
  - When counter=0 the next state is FIN; otherwise decrement.
- FIN, one edge:
  - Apply sign correction to the selected half.
  - MUL: low 32 bits. MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Register result_o, set valid_o=1 and return to IDLE.
- Normal latency: valid_o=1 in the cycle after edge N+33; busy_o=1 from edge N to edge N+33.
- valid_o is never high for two consecutive cycles.
- Back-to-back: busy_o=0 during the valid cycle, so a new start_i can be accepted then.
- Sign rules:
  - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU: both unsigned.
  - Product negated if the operand signs differ.
  - Quotient negated if the signs differ.
  - Remainder takes the dividend's sign.
- Short-circuit cases resolve at edge N+1: state goes directly to FIN-equivalent output, valid_o=1, busy_o=1 for one cycle only.
  - Divide by zero: quotient 0xFFFFFFFF; remainder = a_i.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): quotient 0x80000000; remainder 0.
- kill_i=1 at any edge:
  - State goes to IDLE and busy_o to 0.
  - valid_o is not asserted for the aborted op (valid_o forced 0 that edge).
  - result_o holds its previous value.
- kill_i has priority over start_i in the same cycle; the start is ignored.
- start_i while busy_o=1 is ignored; upstream must hold the instruction via the stall.
- Arithmetic is modulo 2^WIDTH; no exceptions or flags.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: all MUL* ops use a single-cycle combinational 33x33 signed product with sign-extended operands per op. The result latches at edge N+1 with valid_o=1 and busy_o=1 for one cycle. Divides are unchanged.
- Undefined: multiplies use the iterative 33-cycle path above, and no hardware multiplier is inferred.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> result_o=0xFFFFFFEB; valid_o at N+33 (N+1 with MULDIV_FAST_MUL_EN); busy_o high throughout.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU a=-1, b=2 -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD. REM a=-7, b=2 -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14, valid at N+33.
- DIVU a=5, b=0 -> 0xFFFFFFFF at N+1. REM a=5, b=0 -> 5. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at N+1.
- Start DIV, assert kill_i at N+10 -> busy_o=0 at N+11; no valid_o; result_o unchanged. start_i+kill_i same cycle -> no op started.
- Back-to-back: second start_i during the first valid cycle is accepted. rst at N+5 -> all outputs 0, no valid_o.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// ============================================================================
// Module      : ex_muldiv_unit_if
// Description : Request/result bundle between the EX stage and ex_muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             kill_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] result_o;
    logic             valid_o;
    logic             busy_o;

    modport master (
        output start_i, kill_i, op_i, a_i, b_i,
        input  result_o, valid_o, busy_o
    );

    modport slave (
        input  start_i, kill_i, op_i, a_i, b_i,
        output result_o, valid_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Iterative RV32M multiply/divide (shift-add, restoring divide).
//               Optional macro MULDIV_FAST_MUL_EN: single-cycle multiplies.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  wire logic         clk,
    input  wire logic         rst,
    ex_muldiv_unit_if.slave   bus
);
    localparam logic [1:0]       c_st_idle  = 2'd0;
    localparam logic [1:0]       c_st_calc  = 2'd1;
    localparam logic [1:0]       c_st_fin   = 2'd2;
    localparam logic [WIDTH-1:0] c_ones     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_min      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH-1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opb;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_special;
    logic [WIDTH-1:0] r_result;
    logic             r_valid;

    // ---------------- request decode (from live bus inputs) ----------------
    logic             w_is_div;
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_special_res;
    logic             w_accept;
    logic             w_fast_mul;

    assign w_is_div   = bus.op_i[2];
    assign w_a_signed = bus.op_i[2] ? ~bus.op_i[0] : (bus.op_i[1:0] != 2'b11);
    assign w_b_signed = bus.op_i[2] ? ~bus.op_i[0] : ~bus.op_i[1];
    assign w_neg_a    = w_a_signed & bus.a_i[WIDTH-1];
    assign w_neg_b    = w_b_signed & bus.b_i[WIDTH-1];
    assign w_abs_a    = w_neg_a ? (-bus.a_i) : bus.a_i;
    assign w_abs_b    = w_neg_b ? (-bus.b_i) : bus.b_i;
    assign w_div_zero = w_is_div & (bus.b_i == '0);
    assign w_div_ovf  = w_is_div & ~bus.op_i[0] & (bus.a_i == c_min) & (bus.b_i == c_ones);
    assign w_special  = w_div_zero | w_div_ovf;
    // Divide-by-zero takes precedence; op_i[1] distinguishes REM* from DIV*.
    assign w_special_res = w_div_zero ? (bus.op_i[1] ? bus.a_i : c_ones)
                                      : (bus.op_i[1] ? '0 : c_min);
    assign w_accept   = (r_state == c_st_idle) & bus.start_i & ~bus.kill_i;

`ifdef MULDIV_FAST_MUL_EN
    assign w_fast_mul = ~bus.op_i[2];
`else
    assign w_fast_mul = 1'b0;
`endif

    // ---------------- control FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = (w_special | w_fast_mul) ? c_st_fin : c_st_calc;
                end
            end
            c_st_calc: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_st_fin;
                end
            end
            c_st_fin:  w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
        if (bus.kill_i) begin
            w_state_nxt = c_st_idle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == c_st_calc) | (w_state_nxt == c_st_fin);
        end
    end

    // ---------------- one iteration of each algorithm ----------------
    // Multiply: r_hi:r_lo is the accumulator, r_lo starts as the multiplier.
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi_nxt;
    logic [WIDTH-1:0] w_mul_lo_nxt;

    assign w_mul_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    assign w_mul_hi_nxt = w_mul_sum[WIDTH:1];
    assign w_mul_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    // Divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH+1:0] w_div_diff;
    logic             w_div_fits;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opb};
    assign w_div_fits  = ~w_div_diff[WIDTH+1];
    assign w_rem_nxt   = w_div_fits ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_quo_nxt   = {r_lo[WIDTH-2:0], w_div_fits};

    // ---------------- sign fix-up and result select ----------------
    logic [2*WIDTH-1:0] w_prod_abs;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_fin_res;

    assign w_prod_abs = {r_hi, r_lo};
    assign w_prod_fix = r_neg_q ? (-w_prod_abs) : w_prod_abs;
    assign w_quo_fix  = r_neg_q ? (-r_lo) : r_lo;
    assign w_rem_fix  = r_neg_r ? (-r_hi) : r_hi;

`ifdef MULDIV_FAST_MUL_EN
    logic                      r_ext_a;
    logic                      r_ext_b;
    logic signed [WIDTH:0]     w_fast_x;
    logic signed [WIDTH:0]     w_fast_y;
    logic signed [2*WIDTH+1:0] w_fast_prod;
    logic [WIDTH-1:0]          w_fast_res;

    // Fast path keeps raw operands in r_hi/r_opb with their per-op sign extension bits.
    assign w_fast_x    = {r_ext_a, r_hi};
    assign w_fast_y    = {r_ext_b, r_opb};
    assign w_fast_prod = w_fast_x * w_fast_y;
    assign w_fast_res  = (r_op[1:0] == 2'b00) ? w_fast_prod[WIDTH-1:0]
                                              : w_fast_prod[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        w_fin_res = '0;
        if (r_special) begin
            w_fin_res = r_lo;
        end else begin
            case (r_op)
                3'b000:                 w_fin_res = w_prod_fix[WIDTH-1:0];
                3'b001, 3'b010, 3'b011: w_fin_res = w_prod_fix[2*WIDTH-1:WIDTH];
                3'b100, 3'b101:         w_fin_res = w_quo_fix;
                default:                w_fin_res = w_rem_fix;
            endcase
`ifdef MULDIV_FAST_MUL_EN
            if (!r_op[2]) begin
                w_fin_res = w_fast_res;
            end
`endif
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opb     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_special <= 1'b0;
            r_result  <= '0;
            r_valid   <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
            r_ext_a   <= 1'b0;
            r_ext_b   <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (!bus.kill_i) begin
                case (r_state)
                    c_st_idle: begin
                        if (bus.start_i) begin
                            r_op      <= bus.op_i;
                            r_cnt     <= c_cnt_init;
                            r_hi      <= '0;
                            r_neg_q   <= w_neg_a ^ w_neg_b;
                            r_neg_r   <= w_neg_a;
                            r_special <= w_special;
                            if (w_special) begin
                                r_lo  <= w_special_res;
                                r_opb <= '0;
                            end else if (w_is_div) begin
                                r_lo  <= w_abs_a;
                                r_opb <= w_abs_b;
                            end else begin
                                r_lo  <= w_abs_b;
                                r_opb <= w_abs_a;
                            end
`ifdef MULDIV_FAST_MUL_EN
                            if (w_fast_mul) begin
                                r_hi    <= bus.a_i;
                                r_opb   <= bus.b_i;
                                r_ext_a <= w_neg_a;
                                r_ext_b <= w_neg_b;
                            end
`endif
                        end
                    end
                    c_st_calc: begin
                        if (r_op[2]) begin
                            r_hi <= w_rem_nxt;
                            r_lo <= w_quo_nxt;
                        end else begin
                            r_hi <= w_mul_hi_nxt;
                            r_lo <= w_mul_lo_nxt;
                        end
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    c_st_fin: begin
                        r_result <= w_fin_res;
                        r_valid  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.result_o = r_result;
    assign bus.valid_o  = r_valid;
    assign bus.busy_o   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Directed vector bench for ex_muldiv_unit (results, latency, kill, reset).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
    localparam int c_mul_lat = 1;
`else
    localparam int c_mul_lat = 33;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.WIDTH(32)) bus_if();

    ex_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drives one start pulse; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus_if.op_i    = op;
        bus_if.a_i     = a;
        bus_if.b_i     = b;
        bus_if.start_i = 1'b1;
        @(negedge clk);
        bus_if.start_i = 1'b0;
    endtask

    // k0 = number of edges since acceptance plus one at the current falling edge.
    task automatic wait_valid(input int k0, output int lat, output logic [31:0] res, output int busy_ok);
        lat     = -1;
        res     = 'x;
        busy_ok = 1;
        for (int k = k0; k <= 80; k++) begin
            if (bus_if.valid_o === 1'b1) begin
                lat = k - 1;
                res = bus_if.result_o;
                if (bus_if.busy_o !== 1'b0) busy_ok = 0;
                return;
            end
            if (bus_if.busy_o !== 1'b1) busy_ok = 0;
            @(negedge clk);
        end
    endtask

    task automatic watch_quiet(input int n, input logic [31:0] ref_res, output int n_valid, output int n_moved);
        n_valid = 0;
        n_moved = 0;
        for (int k = 0; k < n; k++) begin
            if (bus_if.valid_o !== 1'b0) n_valid++;
            if (bus_if.result_o !== ref_res) n_moved++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          lat;
        int          busy_ok;
        int          n_valid;
        int          n_moved;
        logic [31:0] res;
        logic [31:0] prev;

        vecs.push_back('{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, c_mul_lat, "mul_7_m3"});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, c_mul_lat, "mulhu_max"});
        vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, c_mul_lat, "mulh_m1_m1"});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, c_mul_lat, "mulhsu_m1_2"});
        vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, c_mul_lat, "mulh_min_min"});
        vecs.push_back('{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, c_mul_lat, "mul_shift"});
        vecs.push_back('{3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, c_mul_lat, "mulhu_carry"});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, "div_m7_2"});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, "rem_m7_2"});
        vecs.push_back('{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2"});
        vecs.push_back('{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33, "rem_7_m2"});
        vecs.push_back('{3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33, "divu_100_7"});
        vecs.push_back('{3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33, "remu_100_7"});
        vecs.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, "divu_no_ovf"});
        vecs.push_back('{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "remu_no_ovf"});
        vecs.push_back('{3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1, "divu_by_0"});
        vecs.push_back('{3'b110, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1, "rem_by_0"});
        vecs.push_back('{3'b100, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 1, "div_neg_by_0"});
        vecs.push_back('{3'b111, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 1, "remu_by_0"});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf"});
        vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf"});

        rst            = 1'b1;
        bus_if.start_i = 1'b0;
        bus_if.kill_i  = 1'b0;
        bus_if.op_i    = '0;
        bus_if.a_i     = '0;
        bus_if.b_i     = '0;
        repeat (3) @(negedge clk);
        check32("reset_result", bus_if.result_o, 32'h0);
        check32("reset_valid", {31'b0, bus_if.valid_o}, 32'h0);
        check32("reset_busy", {31'b0, bus_if.busy_o}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Each op issues in the valid cycle of the previous one (back-to-back).
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_valid(1, lat, res, busy_ok);
            check32({vecs[i].name, "_result"}, res, vecs[i].exp);
            check_int({vecs[i].name, "_latency"}, lat, vecs[i].lat);
            check_int({vecs[i].name, "_busy"}, busy_ok, 1);
        end
        @(negedge clk);
        check32("valid_single_cycle", {31'b0, bus_if.valid_o}, 32'h0);

        // start while busy is ignored; back-to-back start in the valid cycle is accepted.
        issue(3'b101, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        bus_if.op_i    = 3'b000;
        bus_if.a_i     = 32'd3;
        bus_if.b_i     = 32'd3;
        bus_if.start_i = 1'b1;
        @(negedge clk);
        bus_if.start_i = 1'b0;
        wait_valid(5, lat, res, busy_ok);
        check32("busy_start_ignored_result", res, 32'd14);
        check_int("busy_start_ignored_latency", lat, 33);
        issue(3'b111, 32'd100, 32'd7);
        wait_valid(1, lat, res, busy_ok);
        check32("b2b_second_result", res, 32'd2);
        check_int("b2b_second_latency", lat, 33);
        @(negedge clk);

        // kill sampled at edge N+10 of a divide
        prev = bus_if.result_o;
        issue(3'b100, 32'hFFFF_FFF9, 32'd2);
        repeat (9) @(negedge clk);
        bus_if.kill_i = 1'b1;
        @(negedge clk);
        bus_if.kill_i = 1'b0;
        check32("kill_busy_low", {31'b0, bus_if.busy_o}, 32'h0);
        watch_quiet(40, prev, n_valid, n_moved);
        check_int("kill_no_valid", n_valid, 0);
        check_int("kill_result_held", n_moved, 0);

        // start and kill together: nothing starts
        bus_if.op_i    = 3'b101;
        bus_if.a_i     = 32'd50;
        bus_if.b_i     = 32'd5;
        bus_if.start_i = 1'b1;
        bus_if.kill_i  = 1'b1;
        @(negedge clk);
        bus_if.start_i = 1'b0;
        bus_if.kill_i  = 1'b0;
        check32("start_kill_busy", {31'b0, bus_if.busy_o}, 32'h0);
        watch_quiet(40, prev, n_valid, n_moved);
        check_int("start_kill_no_valid", n_valid, 0);

        // synchronous reset at edge N+5
        issue(3'b101, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check32("midop_reset_result", bus_if.result_o, 32'h0);
        check32("midop_reset_busy", {31'b0, bus_if.busy_o}, 32'h0);
        watch_quiet(40, 32'h0, n_valid, n_moved);
        check_int("midop_reset_no_valid", n_valid, 0);

        // unit still operational after reset
        issue(3'b100, 32'hFFFF_FFF9, 32'd2);
        wait_valid(1, lat, res, busy_ok);
        check32("post_reset_div", res, 32'hFFFF_FFFD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
